lfsr_period_monitor: RTL
========================

# lfsr_period_monitor

Downstream consumer of the 8-flop dual-chain LFSR. Takes the six LFSR outputs as a 6-bit word and, on request, measures the repeat period of one 3-bit half: upper chain x2..x0 or lower chain x5..x3. It also continuously flags a frozen LFSR word. It returns results to the control logic through a valid/ready handshake.

## Interface
- CNT_W, 8: width of the period counter and the ones counter.
- TIMEOUT, 255: maximum count before a measurement is abandoned; must be ≤ 2^CNT_W−1.
- STUCK_LIMIT, 4: number of consecutive unchanged cycles that sets `stuck`; must be ≥ 2.
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- lfsr_word  in  6  bit i = LFSR output x_i.
- sel  in  1  0 = upper half [2:0], 1 = lower half [5:3]; sampled with `start`.
- start  in  1  measurement request; single-cycle pulse or level.
- busy  out  1  high in ARM or MEASURE.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- period  out  CNT_W  measured period; 0 on timeout.
- timeout  out  1  measurement hit TIMEOUT.
- ones  out  CNT_W  count of ones on the serial bit of the selected half (bit 0 or bit 3) during the window.
- stuck  out  1  sticky frozen-word flag.

## Operation
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE:
  - `start`=1 → ARM.
  - `sel` is latched into `sel_q`.
- ARM, one cycle:
  - `ref` ← selected half of `lfsr_word`.
  - count ← 0, ones ← 0.
  - Next state is MEASURE.
- MEASURE, every cycle:
  - count ← count+1.
  - ones ← ones + serial bit.
  - If selected half == `ref`: period ← count+1, timeout ← 0, go to DONE.
  - Else if count+1 == TIMEOUT: period ← 0, timeout ← 1, go to DONE.
  - A match and the TIMEOUT limit in the same cycle resolve as a match.
- DONE:
  - `res_valid`=1; `period`, `timeout` and `ones` are held stable.
  - `res_valid` & `res_ready` → IDLE.
  - `start` in DONE is ignored; `start` in ARM or MEASURE is ignored.
- Stuck detector:
  - Runs in every state and compares `lfsr_word` with its value on the previous cycle.
  - A run counter increments while the word is equal and clears on any change; it saturates at STUCK_LIMIT.
  - `stuck` ← 1 when the run counter reaches STUCK_LIMIT−1 with the word still equal, i.e. on the STUCK_LIMIT-th identical sample.
  - `stuck` is sticky and is cleared only by reset or by `start` accepted in IDLE.
- Arithmetic: all counters are unsigned CNT_W. `ones` cannot overflow because it is ≤ count < TIMEOUT.

## Timing
- Reset values: state IDLE; busy 0; res_valid 0; period 0; timeout 0; ones 0; stuck 0; internal `ref`, count and run counter 0. The previous-word register resets to 0.
- Latency: start sampled at edge N → ARM at N+1. The first compare happens at N+2. A period P yields `res_valid` at edge N+1+P.
- The handshake completes on the edge where valid & ready are both 1. `res_valid` drops on the following cycle; there is no back-to-back result.
- Reset asserted mid-measurement forces IDLE immediately and asynchronously. All outputs take their reset values; no partial result is produced.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `LFSR_MON_ONES_EN`.
- Defined: the ones counter is built and `ones` reports as in Operation.
- Undefined: there is no ones counter; the `ones` port still exists and is tied to 0.
- Period, timeout and stuck behaviour are identical in both builds.

## Structure
- Shared package `lfsr_mon_pkg` holds:
  - state enum (IDLE, ARM, MEASURE, DONE);
  - constants `SEL_UPPER`=0 and `SEL_LOWER`=1;
  - the half-slice bit ranges.
- Sub-module `lfsr_mon_stuck`: previous-word register, run counter and sticky flag. Its ports are clock, reset, word, clear and stuck.

## Test plan
- sel=0, upper half driven 1,2,4,1,2,4…; start → period=3, timeout=0, res_valid 4 cycles after start; ones=1 with the macro (serial bit 1,0,0).
- sel=1, lower half constant 5 with the upper half changing → period=1, stuck stays 0.
- TIMEOUT=10, selected half never repeats the ref value → res_valid with period=0, timeout=1 at start+11.
- res_ready held low for 5 cycles in DONE, with start pulsed meanwhile → outputs stable and start ignored; IDLE one cycle after ready.
- lfsr_word frozen at 6'h2A for 4 cycles → stuck=1 after the 4th identical sample; it stays 1 after the word changes and clears on the next accepted start.
- Reset asserted in MEASURE at count=5 → busy, res_valid, period and ones are 0 immediately; a subsequent start measures from scratch.

Source files
------------

// File: rtl/lfsr_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_mon_pkg
// Description : Shared FSM state type, half-select constants and half-slice
//               helpers for the LFSR period monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic SEL_UPPER = 1'b0;
    localparam logic SEL_LOWER = 1'b1;

    // Bit ranges of the two 3-bit chain halves inside the 6-bit word
    localparam int WORD_W    = 6;
    localparam int HALF_W    = 3;
    localparam int UPPER_MSB = 2;
    localparam int UPPER_LSB = 0;
    localparam int LOWER_MSB = 5;
    localparam int LOWER_LSB = 3;

    // Selected half; its bit 0 is the serial output of that chain
    function automatic logic [HALF_W-1:0] get_half(input logic [WORD_W-1:0] word,
                                                   input logic              sel);
        return (sel == SEL_LOWER) ? word[LOWER_MSB:LOWER_LSB]
                                  : word[UPPER_MSB:UPPER_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_mon_stuck.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_mon_stuck
// Description : Frozen-word detector. Counts consecutive identical samples and
//               raises a sticky flag on the STUCK_LIMIT-th identical sample.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_mon_stuck
    import lfsr_mon_pkg::*;
#(
    parameter int STUCK_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_clear,
    output logic              o_stuck
);

    localparam int RUN_W = $clog2(STUCK_LIMIT + 1);
    // Run value that, when reached, marks the STUCK_LIMIT-th identical sample
    localparam logic [RUN_W-1:0] c_run_set = RUN_W'(STUCK_LIMIT - 2);
    localparam logic [RUN_W-1:0] c_run_max = RUN_W'(STUCK_LIMIT);

    logic [WORD_W-1:0] r_prev;
    logic [RUN_W-1:0]  r_run;
    logic              r_stuck;
    logic              w_equal;

    assign w_equal = (i_word == r_prev);

    // Previous-word register and saturating run-length counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_run  <= '0;
        end else begin
            r_prev <= i_word;
            if (!w_equal) begin
                r_run <= '0;
            end else if (r_run != c_run_max) begin
                r_run <= r_run + 1'b1;
            end
        end
    end

    // Sticky flag; a fresh detection wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stuck <= 1'b0;
        end else if (w_equal && (r_run == c_run_set)) begin
            r_stuck <= 1'b1;
        end else if (i_clear) begin
            r_stuck <= 1'b0;
        end
    end

    assign o_stuck = r_stuck;

endmodule
`default_nettype wire

// File: rtl/lfsr_period_monitor.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_period_monitor
// Description : Measures the repeat period of one 3-bit half of a 6-bit LFSR
//               word, flags a frozen word, and returns results over a
//               valid/ready handshake.
//               Macro LFSR_MON_ONES_EN builds the ones counter; without it
//               o_ones is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_period_monitor
    import lfsr_mon_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT     = 255,
    parameter int STUCK_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WORD_W-1:0] i_lfsr_word,
    input  logic              i_sel,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic [CNT_W-1:0]  o_period,
    output logic              o_timeout,
    output logic [CNT_W-1:0]  o_ones,
    output logic              o_stuck
);

    localparam logic [CNT_W-1:0] c_timeout = CNT_W'(TIMEOUT);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_sel_q;
    logic [HALF_W-1:0]  r_ref;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_period;
    logic               r_timeout;

    logic [HALF_W-1:0]  w_half;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_match;
    logic               w_limit;
    logic               w_start_acc;

    assign w_half      = get_half(i_lfsr_word, r_sel_q);
    assign w_cnt_inc   = r_count + 1'b1;
    assign w_match     = (w_half == r_ref);
    assign w_limit     = (w_cnt_inc == c_timeout);
    assign w_start_acc = (r_state == IDLE) && i_start;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start)             w_state_nxt = ARM;
            ARM:                              w_state_nxt = MEASURE;
            MEASURE: if (w_match || w_limit)  w_state_nxt = DONE;
            DONE:    if (i_res_ready)         w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    // Output decode from the state register only
    always_comb begin
        o_busy      = (r_state == ARM) || (r_state == MEASURE);
        o_res_valid = (r_state == DONE);
    end

    // Measurement datapath; a match outranks the timeout limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_q   <= SEL_UPPER;
            r_ref     <= '0;
            r_count   <= '0;
            r_period  <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) r_sel_q <= i_sel;
                end
                ARM: begin
                    r_ref   <= w_half;
                    r_count <= '0;
                end
                MEASURE: begin
                    r_count <= w_cnt_inc;
                    if (w_match) begin
                        r_period  <= w_cnt_inc;
                        r_timeout <= 1'b0;
                    end else if (w_limit) begin
                        r_period  <= '0;
                        r_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_period  = r_period;
    assign o_timeout = r_timeout;

`ifdef LFSR_MON_ONES_EN
    logic [CNT_W-1:0] r_ones;
    logic             w_serial;

    assign w_serial = w_half[0];

    // Ones accumulated over the same cycles that advance the period count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ones <= '0;
        end else if (r_state == ARM) begin
            r_ones <= '0;
        end else if (r_state == MEASURE) begin
            r_ones <= r_ones + CNT_W'(w_serial);
        end
    end

    assign o_ones = r_ones;
`else
    assign o_ones = '0;
`endif

    lfsr_mon_stuck #(
        .STUCK_LIMIT (STUCK_LIMIT)
    ) u_stuck (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_word  (i_lfsr_word),
        .i_clear (w_start_acc),
        .o_stuck (o_stuck)
    );

endmodule
`default_nettype wire
